// File: rtl/pe_pkg.sv
// Shared constants and state encoding for the PE result write-back path.
package pe_pkg;

  localparam int PE_VECTOR_SIZE = 64;
  localparam int PE_L_RAM_SIZE  = 6;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_WRITE_ENC = 2'd1;
  localparam logic [1:0] ST_SUM_ENC   = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  localparam logic [3:0]  BRAM_WE_ALL  = 4'hF;
  localparam logic [3:0]  BRAM_WE_NONE = 4'h0;
  localparam logic [31:0] WORD_STRIDE  = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE_ENC,
    S_WRITE = ST_WRITE_ENC,
    S_SUM   = ST_SUM_ENC,
    S_DONE  = ST_DONE_ENC
  } pe_wb_state_e;

endpackage

// File: rtl/pe_result_bank.sv
// Snapshot bank for PE results: parallel load on capture, registered indexed read.
module pe_result_bank
  import pe_pkg::*;
#(
  parameter int VECTOR_SIZE = PE_VECTOR_SIZE,
  parameter int L_RAM_SIZE  = PE_L_RAM_SIZE
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     load,
  input  logic [32*VECTOR_SIZE-1:0] load_data,
  input  logic                     rd_en,
  input  logic [L_RAM_SIZE-1:0]    rd_idx,
  input  logic                     ovr_en,
  input  logic [31:0]              ovr_data,
  output logic [31:0]              rd_data
);

  logic [31:0] bank [VECTOR_SIZE];
  logic [31:0] rd_word;

  // The bank itself carries no reset; only the read register does.
  always_ff @(posedge aclk) begin
    if (load) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        bank[i] <= load_data[32*i +: 32];
      end
    end
  end

  assign rd_word = bank[rd_idx];

  // Word 0 is taken straight from the load bus so the first write follows the capture edge.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_data <= '0;
    end else if (load) begin
      rd_data <= load_data[31:0];
    end else if (ovr_en) begin
      rd_data <= ovr_data;
    end else if (rd_en) begin
      rd_data <= rd_word;
    end
  end

endmodule

// File: rtl/pe_result_writer.sv
// Captures PE results into a bank and streams them to BRAM one word per cycle.
// Optional trailing checksum write is compiled in with PE_WB_CHECKSUM_EN.
module pe_result_writer
  import pe_pkg::*;
#(
  parameter int          VECTOR_SIZE = PE_VECTOR_SIZE,
  parameter int          L_RAM_SIZE  = PE_L_RAM_SIZE,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      capture,
  input  logic [32*VECTOR_SIZE-1:0] results,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun,
  output logic [31:0]               BRAM_ADDR,
  output logic [31:0]               BRAM_WRDATA,
  output logic [3:0]                BRAM_WE,
  output pe_wb_state_e              dbg_state
);

  typedef logic [L_RAM_SIZE:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(VECTOR_SIZE - 1);

  pe_wb_state_e          state, state_n;
  idx_t                  idx;
  logic                  accept, step, last;
  logic [L_RAM_SIZE-1:0] rd_idx;
  logic                  ovr_en;
  logic [31:0]           ovr_data;

  // capture has no back-pressure: it is accepted only in S_IDLE, otherwise it is dropped and flagged.
  assign accept = (state == S_IDLE) && capture;
  assign last   = (state == S_WRITE) && (idx == LAST_IDX);
  assign step   = (state == S_WRITE) && (idx != LAST_IDX);
  assign rd_idx = L_RAM_SIZE'(idx + 1'b1);

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (capture) state_n = S_WRITE;
      S_WRITE: begin
        if (idx == LAST_IDX) begin
`ifdef PE_WB_CHECKSUM_EN
          state_n = S_SUM;
`else
          state_n = S_DONE;
`endif
        end
      end
      S_SUM:   state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      idx <= '0;
    end else if (accept) begin
      idx <= '0;
    end else if (state == S_WRITE) begin
      idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      overrun <= 1'b0;
    end else if (accept) begin
      overrun <= 1'b0;
    end else if (capture && busy) begin
      overrun <= 1'b1;
    end
  end

  // Address and enables are registered alongside the bank read so all three line up.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      BRAM_ADDR <= '0;
      BRAM_WE   <= BRAM_WE_NONE;
    end else if (accept) begin
      BRAM_ADDR <= BASE_ADDR;
      BRAM_WE   <= BRAM_WE_ALL;
    end else if (step) begin
      BRAM_ADDR <= BRAM_ADDR + WORD_STRIDE;
      BRAM_WE   <= BRAM_WE_ALL;
    end else if (last) begin
`ifdef PE_WB_CHECKSUM_EN
      BRAM_ADDR <= BRAM_ADDR + WORD_STRIDE;
      BRAM_WE   <= BRAM_WE_ALL;
`else
      BRAM_WE   <= BRAM_WE_NONE;
`endif
    end else begin
      BRAM_WE   <= BRAM_WE_NONE;
    end
  end

`ifdef PE_WB_CHECKSUM_EN
  logic [31:0] acc;

  // Accumulates the word presented this cycle; the final sum folds in the last word.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc <= '0;
    end else if (accept) begin
      acc <= '0;
    end else if (state == S_WRITE) begin
      acc <= acc + BRAM_WRDATA;
    end
  end

  assign ovr_en   = last;
  assign ovr_data = acc + BRAM_WRDATA;
`else
  assign ovr_en   = 1'b0;
  assign ovr_data = '0;
`endif

  pe_result_bank #(
    .VECTOR_SIZE (VECTOR_SIZE),
    .L_RAM_SIZE  (L_RAM_SIZE)
  ) u_bank (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (accept),
    .load_data (results),
    .rd_en     (step),
    .rd_idx    (rd_idx),
    .ovr_en    (ovr_en),
    .ovr_data  (ovr_data),
    .rd_data   (BRAM_WRDATA)
  );

endmodule

// File: tb/tb_pe_result_writer.sv
// Directed bench for pe_result_writer: nominal stream, snapshot, overrun, reset, wrap.
module tb_pe_result_writer;
  import pe_pkg::*;

  localparam int VS = 64;
  localparam int MAX_CYC = 300;
`ifdef PE_WB_CHECKSUM_EN
  localparam int          CK   = 1;
  localparam logic [31:0] BASE = 32'h0000_1000;
`else
  localparam int          CK   = 0;
  localparam logic [31:0] BASE = 32'h0000_0000;
`endif

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              capture = 1'b0;
  logic              capture_w = 1'b0;
  logic [32*VS-1:0]  results = '0;
  logic [127:0]      results_w = '0;

  logic              busy, done, overrun;
  logic [31:0]       bram_addr, bram_wrdata;
  logic [3:0]        bram_we;
  pe_wb_state_e      state;

  logic              busy_w, done_w, overrun_w;
  logic [31:0]       addr_w, data_w;
  logic [3:0]        we_w;
  pe_wb_state_e      state_w;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [31:0] exp_q[$];
  int          done_cnt, done_cyc, busy_cnt, bad_we;
  bit          timed_out;
  logic        rst_busy;
  logic [3:0]  rst_we;

  pe_result_writer #(.VECTOR_SIZE(VS), .L_RAM_SIZE(6), .BASE_ADDR(BASE)) dut (
    .aclk(aclk), .aresetn(aresetn), .capture(capture), .results(results),
    .busy(busy), .done(done), .overrun(overrun),
    .BRAM_ADDR(bram_addr), .BRAM_WRDATA(bram_wrdata), .BRAM_WE(bram_we),
    .dbg_state(state)
  );

  pe_result_writer #(.VECTOR_SIZE(4), .L_RAM_SIZE(2), .BASE_ADDR(32'hFFFF_FFF8)) dut_w (
    .aclk(aclk), .aresetn(aresetn), .capture(capture_w), .results(results_w),
    .busy(busy_w), .done(done_w), .overrun(overrun_w),
    .BRAM_ADDR(addr_w), .BRAM_WRDATA(data_w), .BRAM_WE(we_w),
    .dbg_state(state_w)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic start_job();
    capture = 1'b1;
    @(posedge aclk); #1;
    capture = 1'b0;
  endtask

  // Records every cycle of a job, starting with the cycle after the capture edge.
  task automatic collect(input int inj_cap, input int inj_rst, input int snap, input logic [31:0] snap_word);
    int cyc;
    bit fin;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; bad_we = 0; timed_out = 0;
    rst_busy = 1'b1; rst_we = 4'hF;
    cyc = 1; fin = 0;
    while (!fin) begin
      if (bram_we == 4'hF) begin
        wr_addr.push_back(bram_addr);
        wr_data.push_back(bram_wrdata);
        wr_cyc.push_back(cyc);
      end else if (bram_we != 4'h0) begin
        bad_we++;
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (busy === 1'b1) busy_cnt++;
      if (inj_rst > 0 && cyc == inj_rst + 1) begin rst_busy = busy; rst_we = bram_we; end
      capture = (cyc == inj_cap);
      if (cyc == snap) results = {VS{snap_word}};
      if (inj_rst > 0) begin
        if (cyc == inj_rst)      aresetn = 1'b0;
        if (cyc == inj_rst + 3)  aresetn = 1'b1;
        if (cyc == inj_rst + 30) fin = 1;
      end else if (done_cnt > 0 && busy === 1'b0) begin
        fin = 1;
      end
      if (cyc >= MAX_CYC) begin timed_out = 1; fin = 1; end
      if (!fin) begin @(posedge aclk); #1; cyc++; end
    end
    capture = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (bram_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bram_addr); end
    checks++; if (bram_wrdata !== 32'h0) begin errors++; $display("FAIL reset_wrdata: got %h want 0", bram_wrdata); end
    checks++; if (bram_we !== 4'h0) begin errors++; $display("FAIL reset_we: got %h want 0", bram_we); end
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_nominal();
    for (int i = 0; i < VS; i++) results[32*i +: 32] = 32'hA000_0000 + 32'(i);
    start_job();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nominal_busy_rise: got %b want 1", busy); end
    collect(0, 0, 0, 32'h0);
    checks++; if (timed_out) begin errors++; $display("FAIL nominal_timeout: got timeout want done"); end
    exp_q.delete();
    for (int i = 0; i < VS; i++) exp_q.push_back(32'hA000_0000 + 32'(i));
`ifdef PE_WB_CHECKSUM_EN
    exp_q.push_back(32'h0000_07E0);
`endif
    checks++;
    if (wr_data.size() != exp_q.size()) begin
      errors++; $display("FAIL nominal_count: got %0d want %0d", wr_data.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_data.size(); i++) begin
      checks++;
      if (wr_data[i] !== exp_q[i] || wr_addr[i] !== BASE + 32'(4*i) || wr_cyc[i] != i + 1) begin
        errors++;
        $display("FAIL nominal_write[%0d]: got data %h addr %h cyc %0d want data %h addr %h cyc %0d",
                 i, wr_data[i], wr_addr[i], wr_cyc[i], exp_q[i], BASE + 32'(4*i), i + 1);
      end
    end
    checks++; if (done_cyc != VS + 1 + CK) begin errors++; $display("FAIL nominal_done_cycle: got %0d want %0d", done_cyc, VS + 1 + CK); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL nominal_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (busy_cnt != VS + 1 + CK) begin errors++; $display("FAIL nominal_busy_cycles: got %0d want %0d", busy_cnt, VS + 1 + CK); end
    checks++; if (bad_we != 0) begin errors++; $display("FAIL nominal_partial_we: got %0d want 0", bad_we); end
    checks++; if (bram_we !== 4'h0) begin errors++; $display("FAIL nominal_idle_we: got %h want 0", bram_we); end
  endtask

  task automatic test_snapshot();
    int bad;
    for (int i = 0; i < VS; i++) results[32*i +: 32] = 32'h5000_0000 + 32'(i * 256);
    start_job();
    collect(0, 0, 1, 32'hDEAD_BEEF);
    checks++; if (wr_data.size() != VS + CK) begin errors++; $display("FAIL snapshot_count: got %0d want %0d", wr_data.size(), VS + CK); end
    bad = 0;
    for (int i = 0; i < VS && i < wr_data.size(); i++) begin
      checks++;
      if (wr_data[i] !== 32'h5000_0000 + 32'(i * 256)) begin
        errors++;
        $display("FAIL snapshot_data[%0d]: got %h want %h", i, wr_data[i], 32'h5000_0000 + 32'(i * 256));
      end
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < VS; i++) results[32*i +: 32] = 32'hC000_0000 + 32'(i);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b want 0", overrun); end
    start_job();
    collect(10, 0, 9, 32'h1111_1111);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    checks++; if (wr_data.size() != VS + CK) begin errors++; $display("FAIL overrun_count: got %0d want %0d", wr_data.size(), VS + CK); end
    for (int i = 0; i < VS && i < wr_data.size(); i++) begin
      checks++;
      if (wr_data[i] !== 32'hC000_0000 + 32'(i) || wr_addr[i] !== BASE + 32'(4*i)) begin
        errors++;
        $display("FAIL overrun_write[%0d]: got data %h addr %h want data %h addr %h",
                 i, wr_data[i], wr_addr[i], 32'hC000_0000 + 32'(i), BASE + 32'(4*i));
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL overrun_done_pulses: got %0d want 1", done_cnt); end
  endtask

  // Runs immediately after test_overrun: the capture lands in the single idle cycle.
  task automatic test_back_to_back();
    for (int i = 0; i < VS; i++) results[32*i +: 32] = 32'hE000_0000 + 32'(i);
    start_job();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_clear: got %b want 0", overrun); end
    checks++;
    if (bram_we !== 4'hF || bram_addr !== BASE || bram_wrdata !== 32'hE000_0000) begin
      errors++;
      $display("FAIL b2b_first_write: got we %h addr %h data %h want we f addr %h data e0000000",
               bram_we, bram_addr, bram_wrdata, BASE);
    end
    collect(0, 0, 0, 32'h0);
    checks++; if (wr_data.size() != VS + CK) begin errors++; $display("FAIL b2b_count: got %0d want %0d", wr_data.size(), VS + CK); end
    checks++; if (done_cyc != VS + 1 + CK) begin errors++; $display("FAIL b2b_done_cycle: got %0d want %0d", done_cyc, VS + 1 + CK); end
    checks++;
    if (wr_data.size() > 0 && wr_data[wr_data.size() - 1 - CK] !== 32'hE000_003F) begin
      errors++; $display("FAIL b2b_last_data: got %h want e000003f", wr_data[wr_data.size() - 1 - CK]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < VS; i++) results[32*i +: 32] = 32'h7000_0000 + 32'(i);
    start_job();
    collect(0, 20, 0, 32'h0);
    checks++; if (rst_we !== 4'h0) begin errors++; $display("FAIL rstmid_we: got %h want 0", rst_we); end
    checks++; if (rst_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", rst_busy); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_done: got %0d pulses want 0", done_cnt); end
    checks++; if (wr_data.size() != 20) begin errors++; $display("FAIL rstmid_count: got %0d want 20", wr_data.size()); end
    for (int i = 0; i < VS; i++) results[32*i +: 32] = 32'h3000_0000 + 32'(i);
    start_job();
    checks++;
    if (bram_we !== 4'hF || bram_addr !== BASE || bram_wrdata !== 32'h3000_0000) begin
      errors++;
      $display("FAIL rstmid_restart: got we %h addr %h data %h want we f addr %h data 30000000",
               bram_we, bram_addr, bram_wrdata, BASE);
    end
    collect(0, 0, 0, 32'h0);
    checks++; if (wr_data.size() != VS + CK) begin errors++; $display("FAIL rstmid_restart_count: got %0d want %0d", wr_data.size(), VS + CK); end
  endtask

`ifdef PE_WB_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 0; i < VS; i++) results[32*i +: 32] = 32'(i + 1);
    start_job();
    collect(0, 0, 0, 32'h0);
    checks++;
    if (wr_data.size() != VS + 1) begin
      errors++; $display("FAIL checksum_count: got %0d want %0d", wr_data.size(), VS + 1);
    end else if (wr_addr[VS] !== 32'h0000_1100 || wr_data[VS] !== 32'h0000_0820) begin
      errors++; $display("FAIL checksum_write: got addr %h data %h want addr 00001100 data 00000820", wr_addr[VS], wr_data[VS]);
    end
    checks++; if (done_cyc != 66) begin errors++; $display("FAIL checksum_done_cycle: got %0d want 66", done_cyc); end
  endtask
`endif

  task automatic test_wrap();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0004;
    for (int i = 0; i < 4; i++) results_w[32*i +: 32] = 32'h0000_00F0 + 32'(i);
    capture_w = 1'b1;
    @(posedge aclk); #1;
    capture_w = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (addr_w !== exp_a[c] || we_w !== 4'hF || data_w !== 32'h0000_00F0 + 32'(c)) begin
        errors++;
        $display("FAIL wrap_write[%0d]: got addr %h we %h data %h want addr %h we f data %h",
                 c, addr_w, we_w, data_w, exp_a[c], 32'h0000_00F0 + 32'(c));
      end
      @(posedge aclk); #1;
    end
    repeat (CK) begin @(posedge aclk); #1; end
    checks++; if (done_w !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", done_w); end
    @(posedge aclk); #1;
    checks++; if (busy_w !== 1'b0) begin errors++; $display("FAIL wrap_idle: got busy %b want 0", busy_w); end
    checks++; if (overrun_w !== 1'b0) begin errors++; $display("FAIL wrap_flag: got overrun %b want 0", overrun_w); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_snapshot();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef PE_WB_CHECKSUM_EN
    test_checksum();
`endif
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
